// File: rtl/detector_uart_rx.sv
// 8N1 UART receiver driving the four obstacle-detector flags; pulses/detectors update one clock after the stop sample.
// No backpressure; optional link-loss timeout under `DETECTOR_RX_TIMEOUT_EN (default: link_lost tied 0).
module detector_uart_rx #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 9600,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       front_detector,
  output logic       back_detector,
  output logic       left_detector,
  output logic       right_detector,
  output logic [7:0] data_byte,
  output logic       data_valid,
  output logic       frame_error,
  output logic       link_lost
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic          rx_meta;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [3:0]    det;
  logic          good_stop;

  // Synchronizer flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign good_stop = (state == S_STOP) && (cnt == BIT_LAST) && rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data_byte   <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data_byte  <= shreg;
              data_valid <= 1'b1;
              state      <= S_IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= S_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT_IDLE: begin
          // A held-low break must end before a new frame can start.
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DETECTOR_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;
  logic          link_lost_q;

  // A good frame takes priority over a coincident timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt      <= '0;
      link_lost_q <= 1'b0;
      det         <= '0;
    end else if (good_stop) begin
      to_cnt      <= '0;
      link_lost_q <= 1'b0;
      det         <= shreg[3:0];
    end else if (to_cnt == TW'(TIMEOUT_CYCLES)) begin
      link_lost_q <= 1'b1;
      det         <= 4'hF;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  assign link_lost = link_lost_q;
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) det <= '0;
    else if (good_stop) det <= shreg[3:0];
  end

  assign link_lost = 1'b0;
`endif

  assign front_detector = det[0];
  assign back_detector  = det[1];
  assign left_detector  = det[2];
  assign right_detector = det[3];

endmodule

// File: tb/tb_detector_uart_rx.sv
// Directed bench for detector_uart_rx at 10 clocks per bit; expected values are hand-derived per frame.
module tb_detector_uart_rx;

  localparam int CPB = 10;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       front_detector;
  logic       back_detector;
  logic       left_detector;
  logic       right_detector;
  logic [7:0] data_byte;
  logic       data_valid;
  logic       frame_error;
  logic       link_lost;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int dv_cnt   = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;
  int dv_last  = 0;
  int dv_prev  = 0;
  int dv0;
  int fe0;

  detector_uart_rx #(
    .CLK_FREQ      (1_000_000),
    .BAUD          (100_000),
    .TIMEOUT_CYCLES(500)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .front_detector(front_detector),
    .back_detector (back_detector),
    .left_detector (left_detector),
    .right_detector(right_detector),
    .data_byte     (data_byte),
    .data_valid    (data_valid),
    .frame_error   (frame_error),
    .link_lost     (link_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt  <= dv_cnt + 1;
      dv_prev <= dv_last;
      dv_last <= cyc;
    end
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (data_valid && frame_error) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] dets();
    return {right_detector, left_detector, back_detector, front_detector};
  endfunction

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_b);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dets", {28'd0, dets()}, 32'h0);
    check("rst_byte", {24'd0, data_byte}, 32'h00);
    check("rst_pulses", {30'd0, data_valid, frame_error}, 32'h0);
    check("rst_link_lost", {31'd0, link_lost}, 32'h0);
    rst = 1'b1;
    idle(5);

    // Frame 0x05: front and left set.
    send_frame(8'h05, 1'b1);
    idle(5);
    check("f05_dv_cnt", dv_cnt, 1);
    check("f05_byte", {24'd0, data_byte}, 32'h05);
    check("f05_dets", {28'd0, dets()}, 32'h5);

    // Three-clock low glitch must be rejected.
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    rx  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(20);
    check("glitch_dv", dv_cnt, dv0);
    check("glitch_fe", fe_cnt, fe0);
    send_frame(8'h0A, 1'b1);
    idle(5);
    check("f0a_dv_cnt", dv_cnt, dv0 + 1);
    check("f0a_byte", {24'd0, data_byte}, 32'h0A);
    check("f0a_dets", {28'd0, dets()}, 32'hA);

    // 0xFF with low stop bit, line held low 30 clocks in total.
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'hFF, 1'b0);
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("ferr_fe_cnt", fe_cnt, fe0 + 1);
    check("ferr_dv_cnt", dv_cnt, dv0);
    check("ferr_dets_held", {28'd0, dets()}, 32'hA);
    check("ferr_byte_held", {24'd0, data_byte}, 32'h0A);
    idle(10);
    send_frame(8'h01, 1'b1);
    idle(5);
    check("f01_dv_cnt", dv_cnt, dv0 + 1);
    check("f01_fe_cnt", fe_cnt, fe0 + 1);
    check("f01_dets", {28'd0, dets()}, 32'h1);

    // Back-to-back frames, one-bit stop, no idle gap.
    dv0 = dv_cnt;
    send_frame(8'h03, 1'b1);
    send_frame(8'h0C, 1'b1);
    idle(5);
    check("b2b_dv_cnt", dv_cnt, dv0 + 2);
    check("b2b_gap", dv_last - dv_prev, 100);
    check("b2b_byte", {24'd0, data_byte}, 32'h0C);
    check("b2b_dets", {28'd0, dets()}, 32'hC);

    // Reset pulse during data bit 4 of 0xF3 (bits 4..7 high keep the line idle after release).
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    fork
      send_frame(8'hF3, 1'b1);
      begin
        repeat (55) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_dets", {28'd0, dets()}, 32'h0);
        check("midrst_byte", {24'd0, data_byte}, 32'h00);
        check("midrst_link_lost", {31'd0, link_lost}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
      end
    join
    idle(10);
    check("midrst_no_dv", dv_cnt, dv0);
    check("midrst_no_fe", fe_cnt, fe0);
    send_frame(8'h5A, 1'b1);
    idle(5);
    check("f5a_dv_cnt", dv_cnt, dv0 + 1);
    check("f5a_byte", {24'd0, data_byte}, 32'h5A);
    check("f5a_dets", {28'd0, dets()}, 32'hA);

`ifdef DETECTOR_RX_TIMEOUT_EN
    send_frame(8'h00, 1'b1);
    idle(400);
    check("to_before", {31'd0, link_lost}, 32'h0);
    check("to_before_dets", {28'd0, dets()}, 32'h0);
    idle(110);
    check("to_lost", {31'd0, link_lost}, 32'h1);
    check("to_lost_dets", {28'd0, dets()}, 32'hF);
    send_frame(8'h02, 1'b1);
    idle(5);
    check("to_recover", {31'd0, link_lost}, 32'h0);
    check("to_recover_dets", {28'd0, dets()}, 32'h2);
`else
    check("link_lost_tied", {31'd0, link_lost}, 32'h0);
`endif

    check("dv_fe_overlap", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/detector_uart_rx.md
# detector_uart_rx

Serial receiver for the detector-feedback channel from the car simulator: samples the `rx` line (8N1 UART, LSB first), recovers one byte per frame and drives the four obstacle-detector flags used by the manual, semi-auto and auto driving modules. It sits in the `GTR` top level between the `rx` pin and the mode logic. It is the receiving end paired with the control-command transmitter on `tx`.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz
- `BAUD`, 9600, line rate in bit/s; `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer division, truncated)
- `TIMEOUT_CYCLES`, 100_000_000, link-loss timeout in clocks (used only with `DETECTOR_RX_TIMEOUT_EN`)

Ports:
- `clk` input 1 system clock, rising edge
- `rst` input 1 reset, asynchronous, active-low
- `rx` input 1 serial line from simulator, idle high
- `front_detector` output 1 obstacle ahead
- `back_detector` output 1 obstacle behind
- `left_detector` output 1 obstacle left
- `right_detector` output 1 obstacle right
- `data_byte` output 8 last good received byte
- `data_valid` output 1 one-cycle pulse, good frame received
- `frame_error` output 1 one-cycle pulse, stop bit sampled low
- `link_lost` output 1 timeout flag (tied 0 without `DETECTOR_RX_TIMEOUT_EN`)

## Operation
- `rx` passes through a 2-flop synchronizer; all logic uses the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on `rx_s` == 0, clear the bit counter and go to START.
- START: count `CLKS_PER_BIT/2` clocks, then resample.
  - `rx_s` == 1 is a glitch: return to IDLE with no output.
  - `rx_s` == 0: go to DATA.
- DATA: every `CLKS_PER_BIT` clocks, shift `rx_s` into the shift register, LSB first. After bit 7, go to STOP.
- STOP: after `CLKS_PER_BIT` clocks, sample `rx_s`.
  - 1: load `data_byte`, pulse `data_valid`, update detectors, go to IDLE.
  - 0: pulse `frame_error`, keep all data outputs unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s` == 1, then go to IDLE. A break condition does not retrigger reception.
- Byte mapping: bit0 `front_detector`, bit1 `back_detector`, bit2 `left_detector`, bit3 `right_detector`. Bits [7:4] go to `data_byte` only.
- Detector outputs are registered and hold their value between good frames.
- A new falling edge during STOP is not recognized until the FSM returns to IDLE. Back-to-back frames with a one-bit stop are supported.

## Timing
- Reset values:
  - all detector outputs 0, `data_byte` 8'h00, `data_valid` 0, `frame_error` 0, `link_lost` 0
  - FSM in IDLE, counters 0, synchronizer flops 1
- Reset deasserted mid-frame has no effect on its own. Asserting reset mid-frame aborts the frame immediately and clears all outputs. After reset release the FSM waits for a fresh falling edge.
- Sampling points, with t0 = the first clock where `rx_s` is low:
  - start bit at t0 + `CLKS_PER_BIT/2`
  - data bit n at t0 + `CLKS_PER_BIT/2` + (n+1)·`CLKS_PER_BIT`
  - stop bit at t0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`
- The `data_valid` or `frame_error` pulse, and the detector update, are registered one clock after the stop sample.
- Pin-to-`rx_s` latency is 2 clocks.
- `data_valid` and `frame_error` are never high in the same cycle. Each pulse lasts exactly one clock.

## Configuration
- Macro `DETECTOR_RX_TIMEOUT_EN`.
- Defined:
  - A counter increments every clock and clears on each `data_valid`.
  - When it reaches `TIMEOUT_CYCLES`, set `link_lost` = 1, force all four detectors to 1 (fail-safe: every direction blocked) and saturate the counter.
  - The next `data_valid` clears `link_lost` and loads the detectors from the byte in the same cycle.
  - If `data_valid` and the timeout coincide, `data_valid` wins.
- Undefined: no counter; `link_lost` is constant 0; detectors change only on good frames.

## Test plan
Bench uses `CLK_FREQ`=1_000_000, `BAUD`=100_000 (`CLKS_PER_BIT`=10) and `TIMEOUT_CYCLES`=500.
- Reset then drive frame 8'h05 with stop bit 1 → `data_valid` pulses once; `front_detector`=1, `left_detector`=1, others 0; `data_byte`=8'h05.
- Low glitch of 3 clocks on idle `rx` → no `data_valid`, no `frame_error`, FSM back in IDLE; then frame 8'h0A is received correctly (`back_detector`=1, `right_detector`=1).
- Frame 8'hFF with stop bit 0, `rx` held low 30 clocks, then frame 8'h01 → one `frame_error` pulse and detectors unchanged from the prior value; then `data_valid` with `front_detector`=1 only.
- Two back-to-back frames 8'h03 then 8'h0C, with no idle gap beyond the stop bit → two `data_valid` pulses 100 clocks apart; final detectors left=1, right=1, front=0, back=0.
- Assert `rst` low at data bit 4 of a frame → all outputs 0 immediately; the remainder of that frame produces no pulse; the next full frame is received.
- With `DETECTOR_RX_TIMEOUT_EN`: idle for 500 clocks after a good 8'h00 frame → `link_lost`=1 and all detectors 1; then frame 8'h02 → `link_lost`=0 and only `back_detector`=1.
